// File: rtl/perceptron_train_sequencer_pkg.sv
// Shared types for the perceptron training sequencer.
// Fixed-point sample format, FSM states and the sample record.
package perceptron_train_sequencer_pkg;

  localparam int SFP_W = 16;

  typedef logic signed [SFP_W-1:0] sfp;

  localparam sfp ONE  = 16'sh0100;
  localparam sfp HALF = 16'sh0080;

  localparam int N_IN = 2;

  typedef enum logic [2:0] {
    IDLE,
    TRAIN,
    EVAL,
    DRAIN,
    FINISH
  } seq_state_t;

  typedef struct packed {
    sfp [N_IN-1:0] values;
    sfp            expected;
  } sample_t;

endpackage

// File: rtl/perceptron_train_sequencer_sample_buffer.sv
// Sample store: one synchronous write port, one combinational read port.
// Contents are deliberately not reset.
module perceptron_train_sequencer_sample_buffer #(
  parameter  int DEPTH = 8,
  parameter  int W     = 48,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/perceptron_train_sequencer.sv
// Drives one perceptron through E epochs of train and eval passes
// over an on-chip sample buffer, scoring each eval pass.
module perceptron_train_sequencer
  import perceptron_train_sequencer_pkg::*;
#(
  parameter  int INPUT_UNITS  = N_IN,
  parameter  int MAX_SAMPLES  = 8,
  parameter  int PRED_LATENCY = 1,
  parameter  int EPOCH_W      = 16,
  localparam int AW           = $clog2(MAX_SAMPLES),
  localparam int CW           = AW + 1,
  localparam int VW           = INPUT_UNITS * SFP_W,
  localparam int DW           = $clog2(PRED_LATENCY + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic [AW-1:0]      load_addr,
  input  logic [VW-1:0]      load_values,
  input  logic [SFP_W-1:0]   load_expected,
  input  logic [CW-1:0]      num_samples,
  input  logic [EPOCH_W-1:0] num_epochs,
  input  logic [SFP_W-1:0]   threshold,
  input  logic               start,
  input  logic               abort,
  input  logic [SFP_W-1:0]   prediction,
  output logic [VW-1:0]      values,
  output logic               training,
  output logic [SFP_W-1:0]   expected,
  output logic               busy,
  output logic               done,
  output logic [EPOCH_W-1:0] epoch,
  output logic [CW-1:0]      correct_count
);

  seq_state_t state;

  logic [CW-1:0]      n_lat;
  logic [CW-1:0]      acc;
  logic [EPOCH_W-1:0] e_lat;
  sfp                 thr_lat;
  logic [AW-1:0]      idx;
  logic [AW-1:0]      rd_idx;
  logic [DW-1:0]      dcnt;

  logic [PRED_LATENCY-1:0] dl_valid;
  sfp                      dl_exp [PRED_LATENCY];

  logic [VW+SFP_W-1:0] rd_data;
  logic [VW-1:0]       rd_values;
  logic [SFP_W-1:0]    rd_expected;

  logic               buf_we;
  logic               can_start;
  logic               last;
  logic               last_drain;
  logic               hit;
  logic               more;
  logic [EPOCH_W-1:0] epoch_inc;

  assign buf_we = load_en && (state == IDLE);

  perceptron_train_sequencer_sample_buffer #(
    .DEPTH (MAX_SAMPLES),
    .W     (VW + SFP_W)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (load_addr),
    .wdata ({load_values, load_expected}),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  assign rd_values   = rd_data[VW+SFP_W-1:SFP_W];
  assign rd_expected = rd_data[SFP_W-1:0];

  assign can_start = start && !abort
                  && (num_samples != '0)
                  && (num_samples <= CW'(MAX_SAMPLES));

  assign last       = ({1'b0, idx} == n_lat - CW'(1));
  assign last_drain = (dcnt == DW'(PRED_LATENCY - 1));
  assign epoch_inc  = epoch + EPOCH_W'(1);
  assign more       = (e_lat != '0) && (epoch_inc < e_lat);

  // Threshold-side agreement between the prediction and its delayed label.
  assign hit = dl_valid[PRED_LATENCY-1]
            && (($signed(prediction) < thr_lat)
                == (dl_exp[PRED_LATENCY-1] < thr_lat));

  // Address of the sample to present on the next cycle.
  always_comb begin
    rd_idx = '0;
    if ((state == TRAIN && !last) || state == EVAL)
      rd_idx = idx + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      values        <= '0;
      expected      <= '0;
      training      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      epoch         <= '0;
      correct_count <= '0;
      n_lat         <= '0;
      e_lat         <= '0;
      thr_lat       <= '0;
      idx           <= '0;
      dcnt          <= '0;
      acc           <= '0;
      dl_valid      <= '0;
    end else begin
      done        <= 1'b0;
      dl_valid[0] <= (state == EVAL);
      dl_exp[0]   <= expected;
      for (int i = PRED_LATENCY - 1; i > 0; i--) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_exp[i]   <= dl_exp[i-1];
      end

      if ((state == EVAL || state == DRAIN) && hit)
        acc <= acc + CW'(1);

      if (abort && busy) begin
        state    <= IDLE;
        busy     <= 1'b0;
        training <= 1'b0;
        values   <= '0;
        expected <= '0;
        dl_valid <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (can_start) begin
              n_lat         <= num_samples;
              e_lat         <= num_epochs;
              thr_lat       <= threshold;
              epoch         <= '0;
              correct_count <= '0;
              acc           <= '0;
              dl_valid      <= '0;
              busy          <= 1'b1;
              idx           <= '0;
              values        <= rd_values;
              expected      <= rd_expected;
              training      <= (num_epochs != '0);
              state         <= (num_epochs != '0) ? TRAIN : EVAL;
            end
          end
          TRAIN: begin
            values   <= rd_values;
            expected <= rd_expected;
            if (last) begin
              idx      <= '0;
              training <= 1'b0;
              state    <= EVAL;
            end else begin
              idx <= idx + AW'(1);
            end
          end
          EVAL: begin
            if (last) begin
              values   <= '0;
              expected <= '0;
              dcnt     <= '0;
              state    <= DRAIN;
            end else begin
              idx      <= idx + AW'(1);
              values   <= rd_values;
              expected <= rd_expected;
            end
          end
          DRAIN: begin
            if (!last_drain) begin
              dcnt <= dcnt + DW'(1);
            end else begin
              correct_count <= acc + CW'(hit);
              acc           <= '0;
              if (e_lat != '0) epoch <= epoch_inc;
              if (more) begin
                idx      <= '0;
                training <= 1'b1;
                values   <= rd_values;
                expected <= rd_expected;
                state    <= TRAIN;
              end else begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= FINISH;
              end
            end
          end
          FINISH: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_perceptron_train_sequencer.sv
// Bench for perceptron_train_sequencer: a stand-in perceptron with a
// fixed latency feeds predictions; a schedule model predicts every cycle.
module tb_perceptron_train_sequencer;
  import perceptron_train_sequencer_pkg::*;

  localparam int MS = 8;
  localparam int AW = 3;
  localparam int CW = 4;
  localparam int EW = 16;
  localparam int VW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [VW-1:0] load_values = '0;
  logic [15:0]   load_expected = '0;
  logic [CW-1:0] num_samples = '0;
  logic [EW-1:0] num_epochs = '0;
  logic [15:0]   threshold = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [15:0]   pred1, pred3;

  logic [VW-1:0] v1, v3;
  logic [15:0]   e1, e3;
  logic          tr1, tr3, b1, b3, d1, d3;
  logic [EW-1:0] ep1, ep3;
  logic [CW-1:0] cc1, cc3;

  perceptron_train_sequencer #(.PRED_LATENCY(1)) u_dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_values(load_values), .load_expected(load_expected),
    .num_samples(num_samples), .num_epochs(num_epochs),
    .threshold(threshold), .start(start), .abort(abort),
    .prediction(pred1), .values(v1), .training(tr1), .expected(e1),
    .busy(b1), .done(d1), .epoch(ep1), .correct_count(cc1)
  );

  perceptron_train_sequencer #(.PRED_LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_values(load_values), .load_expected(load_expected),
    .num_samples(num_samples), .num_epochs(num_epochs),
    .threshold(threshold), .start(start), .abort(abort),
    .prediction(pred3), .values(v3), .training(tr3), .expected(e3),
    .busy(b3), .done(d3), .epoch(ep3), .correct_count(cc3)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] m_v0 [MS];
  logic [15:0] m_v1 [MS];
  logic [15:0] m_lab [MS];

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          training;
    logic [VW-1:0] v;
    logic [15:0]   e;
  } obs_t;

  obs_t exp_q [$];
  obs_t o1, o3;
  assign o1 = {b1, d1, tr1, v1, e1};
  assign o3 = {b3, d3, tr3, v3, e3};

  // Stand-in perceptron: mean of the two inputs.
  function automatic logic [15:0] fake(input logic [VW-1:0] v);
    logic signed [15:0] a, b;
    a = v[15:0];
    b = v[31:16];
    return (a >>> 1) + (b >>> 1);
  endfunction

  logic [15:0] p1 [2];
  logic [15:0] p3 [4];
  initial begin
    foreach (p1[i]) p1[i] = '0;
    foreach (p3[i]) p3[i] = '0;
    pred1 = '0;
    pred3 = '0;
    forever begin
      @(negedge clk);
      p1[1] = p1[0];
      p1[0] = fake(v1);
      for (int i = 3; i > 0; i--) p3[i] = p3[i-1];
      p3[0] = fake(v3);
      pred1 = p1[1];
      pred3 = p3[3];
    end
  end

  function automatic int exp_correct(input int n, input logic [15:0] thr);
    int c;
    logic signed [15:0] p, l, t;
    c = 0;
    t = thr;
    for (int k = 0; k < n; k++) begin
      p = fake({m_v1[k], m_v0[k]});
      l = m_lab[k];
      if ((p < t) == (l < t)) c++;
    end
    return c;
  endfunction

  task automatic build_trace(input int n, input int e, input int lat);
    int passes;
    exp_q.delete();
    passes = (e == 0) ? 1 : e;
    for (int p = 0; p < passes; p++) begin
      if (e != 0)
        for (int k = 0; k < n; k++)
          exp_q.push_back({1'b1, 1'b0, 1'b1, m_v1[k], m_v0[k], m_lab[k]});
      for (int k = 0; k < n; k++)
        exp_q.push_back({1'b1, 1'b0, 1'b0, m_v1[k], m_v0[k], m_lab[k]});
      for (int d = 0; d < lat; d++)
        exp_q.push_back({3'b100, 48'h0});
    end
    exp_q.push_back({3'b010, 48'h0});
    exp_q.push_back({3'b000, 48'h0});
  endtask

  task automatic load(input int a, input logic [15:0] x0, x1, lab);
    load_addr     = AW'(a);
    load_values   = {x1, x0};
    load_expected = lab;
    load_en       = 1'b1;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic fill(input int n);
    logic [15:0] x0, x1, lab;
    for (int i = 0; i < n; i++) begin
      x0 = 16'($urandom);
      x1 = 16'($urandom);
      if ($urandom_range(0, 1) == 1) lab = 16'($urandom);
      else lab = ($urandom_range(0, 1) == 1) ? ONE : 16'h0;
      load(i, x0, x1, lab);
      m_v0[i] = x0;
      m_v1[i] = x1;
      m_lab[i] = lab;
    end
  endtask

  task automatic start_run(input int n, input int e, input logic [15:0] thr);
    num_samples = CW'(n);
    num_epochs  = EW'(e);
    threshold   = thr;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({o1, ep1, cc1} !== '0) begin
      n_err++;
      $display("FAIL reset_l1: got %h want 0", {o1, ep1, cc1});
    end
    n_vec++;
    if ({o3, ep3, cc3} !== '0) begin
      n_err++;
      $display("FAIL reset_l3: got %h want 0", {o3, ep3, cc3});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_sequencing;
    fill(3);
    start_run(3, 1, HALF);
    build_trace(3, 1, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (o1 !== exp_q[i]) begin
        n_err++;
        $display("FAIL seq cyc %0d: got %h want %h", i + 1, o1, exp_q[i]);
      end
      if (i == exp_q.size() - 2) begin
        n_vec++;
        if (ep1 !== EW'(1) || cc1 !== CW'(exp_correct(3, HALF))) begin
          n_err++;
          $display("FAIL seq_score: got ep %0d cc %0d want ep 1 cc %0d",
                   ep1, cc1, exp_correct(3, HALF));
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_schedule_random;
    int n, e;
    logic [15:0] thr;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, MS);
      e = $urandom_range(0, 3);
      thr = (r % 2 == 0) ? HALF : 16'($urandom_range(0, 512)) - 16'd256;
      if (r == 0) begin
        n = 4;
        e = 10;
        load(0, 16'h0, 16'h0, 16'h0);
        load(1, ONE, 16'h0, 16'h0);
        load(2, 16'h0, ONE, 16'h0);
        load(3, ONE, ONE, ONE);
        m_v0[0] = 0;   m_v1[0] = 0;   m_lab[0] = 0;
        m_v0[1] = ONE; m_v1[1] = 0;   m_lab[1] = 0;
        m_v0[2] = 0;   m_v1[2] = ONE; m_lab[2] = 0;
        m_v0[3] = ONE; m_v1[3] = ONE; m_lab[3] = ONE;
      end else begin
        fill(n);
      end
      start_run(n, e, thr);
      build_trace(n, e, 1);
      for (int i = 0; i < exp_q.size(); i++) begin
        n_vec++;
        if (o1 !== exp_q[i]) begin
          n_err++;
          $display("FAIL sched r%0d cyc %0d: got %h want %h",
                   r, i + 1, o1, exp_q[i]);
        end
        if (i == exp_q.size() - 2) begin
          n_vec++;
          if (ep1 !== EW'(e) || cc1 !== CW'(exp_correct(n, thr))) begin
            n_err++;
            $display("FAIL sched_score r%0d: got ep %0d cc %0d want ep %0d cc %0d",
                     r, ep1, cc1, e, exp_correct(n, thr));
          end
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_scoring_eval_only;
    load(0, 16'h0200, 16'h0, 16'h0);
    load(1, 16'h0, 16'h0, 16'h0);
    load(2, 16'h0200, 16'h0, ONE);
    load(3, 16'h0, 16'h0, ONE);
    start_run(4, 0, HALF);
    for (int i = 1; i <= 6; i++) begin
      n_vec++;
      if (d1 !== (i == 6)) begin
        n_err++;
        $display("FAIL evalonly_done cyc %0d: got %b want %b", i, d1, i == 6);
      end
      if (i == 6) begin
        n_vec++;
        if (cc1 !== CW'(2) || ep1 !== '0) begin
          n_err++;
          $display("FAIL evalonly_score: got cc %0d ep %0d want cc 2 ep 0",
                   cc1, ep1);
        end
      end
      @(posedge clk); #1;
    end
    m_v0[0] = 16'h0200; m_v1[0] = 0; m_lab[0] = 0;
    m_v0[1] = 0;        m_v1[1] = 0; m_lab[1] = 0;
    m_v0[2] = 16'h0200; m_v1[2] = 0; m_lab[2] = ONE;
    m_v0[3] = 0;        m_v1[3] = 0; m_lab[3] = ONE;
  endtask

  task automatic test_abort;
    int n;
    int seen;
    n = $urandom_range(2, 5);
    fill(n);
    start_run(n, 5, HALF);
    repeat (2 * (2 * n + 1) + 1) @(posedge clk);
    #1;
    n_vec++;
    if (tr1 !== 1'b1 || v1 !== {m_v1[1], m_v0[1]}) begin
      n_err++;
      $display("FAIL abort_pre: got tr %b v %h want tr 1 v %h",
               tr1, v1, {m_v1[1], m_v0[1]});
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_vec++;
    if (o1 !== '0 || cc1 !== CW'(exp_correct(n, HALF)) || ep1 !== EW'(2)) begin
      n_err++;
      $display("FAIL abort_post: got obs %h cc %0d ep %0d want 0 cc %0d ep 2",
               o1, cc1, ep1, exp_correct(n, HALF));
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (d1 || b1) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL abort_nodone: got %0d busy/done cycles want 0", seen);
    end
  endtask

  task automatic test_ignored;
    fill(3);
    start_run(3, 1, HALF);
    build_trace(3, 1, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (o1 !== exp_q[i]) begin
        n_err++;
        $display("FAIL ignored cyc %0d: got %h want %h", i + 1, o1, exp_q[i]);
      end
      start = (i == 1);
      load_en = (i == 1);
      if (i == 1) begin
        num_samples = CW'(2);
        num_epochs = EW'(7);
        load_addr = '0;
        load_values = ~{m_v1[0], m_v0[0]};
        load_expected = ~m_lab[0];
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    load_en = 1'b0;
    start_run(3, 0, HALF);
    build_trace(3, 0, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (o1 !== exp_q[i]) begin
        n_err++;
        $display("FAIL readback cyc %0d: got %h want %h", i + 1, o1, exp_q[i]);
      end
      @(posedge clk); #1;
    end
    start_run(0, 2, HALF);
    @(posedge clk); #1;
    n_vec++;
    if (b1 !== 1'b0 || tr1 !== 1'b0) begin
      n_err++;
      $display("FAIL zero_n: got busy %b tr %b want 0 0", b1, tr1);
    end
  endtask

  task automatic test_rst_midrun;
    fill(4);
    start_run(4, 3, HALF);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++;
    if ({o1, ep1, cc1} !== '0) begin
      n_err++;
      $display("FAIL rst_midrun: got %h want 0", {o1, ep1, cc1});
    end
  endtask

  task automatic test_latency3;
    logic [15:0] thr;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int r = 0; r < 3; r++) begin
      fill(2);
      thr = (r == 0) ? HALF : 16'($urandom_range(0, 512)) - 16'd256;
      start_run(2, 1, thr);
      build_trace(2, 1, 3);
      for (int i = 0; i < exp_q.size(); i++) begin
        n_vec++;
        if (o3 !== exp_q[i]) begin
          n_err++;
          $display("FAIL lat3 r%0d cyc %0d: got %h want %h",
                   r, i + 1, o3, exp_q[i]);
        end
        if (i == exp_q.size() - 2) begin
          n_vec++;
          if (ep3 !== EW'(1) || cc3 !== CW'(exp_correct(2, thr))) begin
            n_err++;
            $display("FAIL lat3_score r%0d: got ep %0d cc %0d want ep 1 cc %0d",
                     r, ep3, cc3, exp_correct(2, thr));
          end
        end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset;
    test_sequencing;
    test_schedule_random;
    test_scoring_eval_only;
    test_abort;
    test_ignored;
    test_rst_midrun;
    test_latency3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/perceptron_train_sequencer.md
Name: perceptron_train_sequencer

Overview:
- Controller that sequences one Perceptron through a full training schedule.
- Holds a small sample buffer of input vectors with expected labels.
- Each epoch streams every sample once with training=1, then every sample once with training=0, and counts threshold-correct predictions.
- Replaces the hand-written stimulus loop used for gate-learning experiments and is the building block for driving MLP layers from on-chip datasets.

Parameters:
- INPUT_UNITS, 2, inputs per sample; equals the driven Perceptron's input_units.
- MAX_SAMPLES, 8, sample buffer depth.
- PRED_LATENCY, 1, cycles from values/training presented to valid prediction (>=1).
- EPOCH_W, 16, width of the epoch counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- load_en  in  1  write one sample into the buffer.
- load_addr  in  $clog2(MAX_SAMPLES)  buffer write index.
- load_values  in  sfp[INPUT_UNITS]  sample inputs.
- load_expected  in  sfp  sample label.
- num_samples  in  $clog2(MAX_SAMPLES)+1  active samples N, 1..MAX_SAMPLES.
- num_epochs  in  EPOCH_W  epoch count E.
- threshold  in  sfp  classification threshold, normally HALF.
- start  in  1  one-cycle start request.
- abort  in  1  stop the run.
- prediction  in  sfp  Perceptron output.
- values  out  sfp[INPUT_UNITS]  to Perceptron.
- training  out  1  to Perceptron.
- expected  out  sfp  label of the sample currently on values; feeds the loss-gradient logic.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- epoch  out  EPOCH_W  current or completed epoch index.
- correct_count  out  $clog2(MAX_SAMPLES)+1  correct predictions in the most recent eval pass.

Behaviour:
Interface:
- One clock, clk.
- Reset rst is synchronous and active-high.
- All outputs are registered.

Reset values:
- values=0, expected=0, training=0, busy=0, done=0, epoch=0, correct_count=0, state=IDLE.
- Buffer contents are not reset.

States: IDLE, TRAIN, EVAL, DRAIN, FINISH.
- IDLE:
  - start=1 and N>=1 latches N, E and threshold, clears epoch and correct_count, and sets busy=1.
  - Goes to TRAIN next cycle, or to EVAL if E==0 (evaluation-only run).
  - start with N==0 is ignored.
  - load_en writes the buffer only in IDLE; it is ignored while busy.
- TRAIN:
  - Cycle k presents sample k on values/expected with training=1, for k=0..N-1.
  - After sample N-1, goes to EVAL.
- EVAL:
  - Presents samples 0..N-1 with training=0.
  - The sample index and label enter a PRED_LATENCY-deep delay line.
  - After sample N-1, goes to DRAIN.
- DRAIN:
  - Waits PRED_LATENCY cycles.
  - On each cycle where the delay line is valid, scores the prediction: correct if (prediction < thr) == (delayed_expected < thr), signed comparison.
  - Scoring is active across EVAL and DRAIN.
  - At the end of DRAIN, correct_count is updated with the pass total, computed in a separate accumulator so correct_count holds the last full pass.
  - epoch increments.
  - If epoch (after increment) < E, goes to TRAIN; otherwise goes to FINISH.
  - For E==0, goes straight to FINISH and epoch stays 0.
- FINISH:
  - done=1 for one cycle, busy=0, training=0.
  - Goes to IDLE.
- Outside TRAIN/EVAL, values and expected hold 0 and training=0.

Cycle counts:
- One epoch is 2N+PRED_LATENCY cycles.
- A run is E*(2N+PRED_LATENCY) cycles plus one FINISH cycle.
- done is asserted exactly one cycle after the last DRAIN cycle.

Edge cases:
- start while busy: ignored.
- abort while busy: next cycle is IDLE with training=0, values=0, busy=0, and no done pulse; correct_count keeps its last completed value.
- rst mid-run: behaves like reset, with all outputs at reset values.
- abort and start in the same cycle in IDLE: abort wins, start is dropped.

Decomposition:
- Package Common:
  - seq_state_t enum.
  - sample_t struct {sfp values[INPUT_UNITS]; sfp expected}.
- FixedPoint already supplies sfp, ONE and HALF; comparisons use plain signed compare, no new helpers needed.
- Sub-module sample_buffer: MAX_SAMPLES-deep register array of sample_t, with one synchronous write port and one combinational read port.
- The FSM, counters, delay line and scorer stay in the top module.

Test Plan:
- AND gate: load 4 samples, N=4, E=10, thr=HALF, learning_rate=ONE, Perceptron with Sigmoid → done after 10*(8+1)+1 cycles, epoch=10, correct_count=4.
- Sequencing check: N=3, E=1, dummy prediction → training high for exactly 3 cycles, then low for 3; values/expected show samples 0,1,2 twice; busy low after done.
- Scoring: E=0, N=4, prediction driven as ONE,0,ONE,0 one cycle late against labels 0,0,ONE,ONE → correct_count=2, epoch=0, done after 4+1+1 cycles.
- Abort mid-run: E=5, assert abort during epoch 2 TRAIN → next cycle busy=0, training=0, no done pulse, correct_count equals the epoch-1 result.
- Ignored requests: start while busy changes nothing; load_en while busy leaves the buffer unchanged (read back via a later E=0 run); start with N=0 keeps busy=0.
- PRED_LATENCY=3 build: E=1, N=2 → one epoch takes 7 cycles; scoring uses labels delayed by 3 cycles and gives the correct count.
